mem_port_arbiter: RTL

Shares the single memory port between the instruction-fetch requester (IF) and the data requester (MEM stage). Fixed data-over-instruction priority, with a starvation guard for fetch.
- Registers and holds each response until the owning stage consumes it, so a stalled stage never re-issues a store.
- Absorbs excp_flush without breaking the downstream req/gnt protocol.
- Sits between the core pipeline and the SRAM/bus bridge.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_prio.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   state_t : arbiter FSM states (idle, request, wait for response, hold response)
//   owner_t : which requester owns the current bus transaction
package mem_port_arbiter_pkg;

    localparam int unsigned AddrWDefault       = 32;
    localparam int unsigned DataWDefault       = 32;
    localparam int unsigned StarveLimitDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_t;

    // Encoding matters: mem_arb_prio reports a data grant as 1'b1.
    typedef enum logic {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Priority select for the shared memory port: data beats fetch, except that a
// fetch kept waiting through STARVE_LIMIT consecutive data grants is forced.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   inst_en     : fetch request pending
//   data_en     : data request pending
//   grant       : an arbitration is being committed this cycle
//   grant_data  : decision for this cycle, 1 = data wins, 0 = fetch wins
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_en,
    input  logic data_en,
    input  logic grant,
    output logic grant_data
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_cnt_q;
    logic            starved;

    assign starved    = inst_en && (starve_cnt_q == CntMax);
    assign grant_data = data_en && !starved;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else if (!inst_en) begin
            starve_cnt_q <= '0;
        end else if (grant) begin
            if (grant_data) begin
                if (starve_cnt_q != CntMax) begin
                    starve_cnt_q <= starve_cnt_q + CntW'(1);
                end
            end else begin
                starve_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the data stage
// (MEM). One transaction is outstanding at a time; the response is registered
// and held until the owning stage consumes it, and a pipeline flush drops the
// response without withdrawing an already-issued bus request.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   excp_flush                       : cancel delivery of the outstanding response
//   inst_en/inst_addr                : fetch request (held until inst_fire)
//   inst_rdata/inst_rdata_valid      : fetch response, held until inst_fire
//   data_en/we/addr/wmask/wdata      : data request (held until data_fire)
//   data_rdata/data_rdata_valid      : load response, held until data_fire
//   data_write_finish                : store completion, held until data_fire
//   mem_req/we/addr/wmask/wdata      : downstream request, stable until mem_gnt
//   mem_gnt                          : downstream accepted the request
//   mem_rvalid/mem_rdata, mem_bvalid : downstream read / write completion pulses
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = AddrWDefault,
    parameter int unsigned DATA_W       = DataWDefault,
    parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                excp_flush,

    input  logic                inst_en,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rdata_valid,
    input  logic                inst_fire,

    input  logic                data_en,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wmask,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rdata_valid,
    output logic                data_write_finish,
    input  logic                data_fire,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_bvalid
);

    state_t state_q;
    owner_t owner_q;
    logic   drop_q;

    logic arb_grant;
    logic arb_data;
    logic resp_hit;
    logic resp_done;
    logic owner_fire;

    // Arbitrate only from idle, and never in a flush cycle.
    assign arb_grant = (state_q == StIdle) && (inst_en || data_en) && !excp_flush;

    // A completion of the wrong type for the latched direction is ignored.
    assign resp_hit = mem_we ? mem_bvalid : mem_rvalid;

    // Zero-wait memory: the response may arrive in the same cycle as the grant.
    assign resp_done = resp_hit && (((state_q == StReq) && mem_gnt) || (state_q == StWait));

    assign owner_fire = (owner_q == OwnInst) ? inst_fire : data_fire;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .reset      (reset),
        .inst_en    (inst_en),
        .data_en    (data_en),
        .grant      (arb_grant),
        .grant_data (arb_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            owner_q           <= OwnInst;
            drop_q            <= 1'b0;
            inst_rdata        <= '0;
            inst_rdata_valid  <= 1'b0;
            data_rdata        <= '0;
            data_rdata_valid  <= 1'b0;
            data_write_finish <= 1'b0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wmask         <= '0;
            mem_wdata         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arb_grant) begin
                        mem_req <= 1'b1;
                        state_q <= StReq;
                        if (arb_data) begin
                            owner_q   <= OwnData;
                            mem_we    <= data_we;
                            mem_addr  <= data_addr;
                            mem_wmask <= data_wmask;
                            mem_wdata <= data_wdata;
                        end else begin
                            owner_q   <= OwnInst;
                            mem_we    <= 1'b0;
                            mem_addr  <= inst_addr;
                            mem_wmask <= '0;
                            mem_wdata <= '0;
                        end
                    end
                end
                StReq: begin
                    // The request stays up until granted even when flushed.
                    if (excp_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (excp_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (owner_fire || excp_flush) begin
                        inst_rdata_valid  <= 1'b0;
                        data_rdata_valid  <= 1'b0;
                        data_write_finish <= 1'b0;
                        state_q           <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Completion overrides the per-state updates above.
            if (resp_done) begin
                if (!mem_we) begin
                    if (owner_q == OwnInst) begin
                        inst_rdata <= mem_rdata;
                    end else begin
                        data_rdata <= mem_rdata;
                    end
                end
                // A flush in the completing cycle counts as a drop too.
                if (drop_q || excp_flush) begin
                    drop_q  <= 1'b0;
                    state_q <= StIdle;
                end else begin
                    state_q <= StHold;
                    if (owner_q == OwnInst) begin
                        inst_rdata_valid <= 1'b1;
                    end else if (mem_we) begin
                        data_write_finish <= 1'b1;
                    end else begin
                        data_rdata_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
